// File: rtl/jenc_line_block_reader.sv
// jenc_line_block_reader
//   Reads one 8-line stripe out of the 64-bit line buffer and streams it to the
//   DCT stage. The buffer is block-major (addr = blk*8 + row), so a linear
//   address counter visits blk 0 rows 0..7, then blk 1, and so on.
//   A 2-entry skid FIFO absorbs the 1-cycle RAM latency. Reads are issued only
//   when the FIFO plus the in-flight read leave room for the new word, so an
//   issued read never has to stall.
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i/num_blocks_i  begin readout of num_blocks_i blocks (1..DEPTH/8)
//   busy_o, done_o        readout in progress / final row handed off (pulse)
//   rd_en_o, rd_addr_o    RAM read port; rd_data_i valid one cycle later
//   row_*_o, row_ready_i  valid/ready row stream with row/block sideband
//   last_o                marks row 7 of the final block
module jenc_line_block_reader #(
    parameter int DEPTH  = 1440,
    parameter int ADDR_W = 11,
    parameter int BLK_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [BLK_W-1:0]  num_blocks_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [63:0]       rd_data_i,
    output logic              row_valid_o,
    input  logic              row_ready_i,
    output logic [63:0]       row_data_o,
    output logic [2:0]        row_idx_o,
    output logic [BLK_W-1:0]  blk_idx_o,
    output logic              last_o
);
    localparam logic [BLK_W-1:0] MAX_NB = BLK_W'(DEPTH / 8);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, end_q;

    // Sideband of the read currently in flight through the RAM
    logic                fl_q;
    logic [2:0]          fl_row_q;
    logic [BLK_W-1:0]    fl_blk_q;
    logic                fl_last_q;

    // Skid FIFO
    logic [63:0]         f_data_q [2];
    logic [2:0]          f_row_q  [2];
    logic [BLK_W-1:0]    f_blk_q  [2];
    logic                f_last_q [2];
    logic                f_rp_q, f_wp_q;
    logic [1:0]          f_cnt_q;

    logic                start_ok, issue_last, pop, room;
    logic [2:0]          occ;

    assign start_ok   = start_i && (num_blocks_i != '0) && (num_blocks_i <= MAX_NB);
    assign issue_last = (addr_q == end_q);
    assign pop        = row_valid_o && row_ready_i;

    // Words that will still be held after this cycle's pop; a new read is
    // allowed while that leaves one free slot for it.
    assign occ  = 3'(f_cnt_q) + 3'(fl_q) - 3'(pop);
    assign room = (occ < 3'd2);

    assign row_valid_o = (f_cnt_q != 2'd0);
    assign row_data_o  = f_data_q[f_rp_q];
    assign row_idx_o   = f_row_q[f_rp_q];
    assign blk_idx_o   = f_blk_q[f_rp_q];
    assign last_o      = f_last_q[f_rp_q];
    assign rd_addr_o   = addr_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok)                  state_d = RUN;
            RUN:     if (rd_en_o && issue_last)     state_d = DRAIN;
            DRAIN:   if (pop && last_o)             state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_o  = (state_q != IDLE);
        rd_en_o = (state_q == RUN) && room;
        done_o  = (state_q == DRAIN) && pop && last_o;
    end

    // Address counter; it parks on the end address after the final read
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            end_q  <= '0;
        end else if (state_q == IDLE && start_ok) begin
            addr_q <= '0;
            end_q  <= (ADDR_W'(num_blocks_i) << 3) - ADDR_W'(1);
        end else if (rd_en_o && !issue_last) begin
            addr_q <= addr_q + ADDR_W'(1);
        end
    end

    // In-flight tracking; clearing fl_q on reset drops the cancelled read
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fl_q      <= 1'b0;
            fl_row_q  <= '0;
            fl_blk_q  <= '0;
            fl_last_q <= 1'b0;
        end else begin
            fl_q      <= rd_en_o;
            fl_row_q  <= addr_q[2:0];
            fl_blk_q  <= BLK_W'(addr_q >> 3);
            fl_last_q <= issue_last;
        end
    end

    // Skid FIFO: push the returning RAM word, pop on handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f_rp_q  <= 1'b0;
            f_wp_q  <= 1'b0;
            f_cnt_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                f_data_q[i] <= '0;
                f_row_q[i]  <= '0;
                f_blk_q[i]  <= '0;
                f_last_q[i] <= 1'b0;
            end
        end else begin
            if (fl_q) begin
                f_data_q[f_wp_q] <= rd_data_i;
                f_row_q[f_wp_q]  <= fl_row_q;
                f_blk_q[f_wp_q]  <= fl_blk_q;
                f_last_q[f_wp_q] <= fl_last_q;
                f_wp_q           <= ~f_wp_q;
            end
            if (pop) f_rp_q <= ~f_rp_q;
            f_cnt_q <= f_cnt_q + 2'(fl_q) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_jenc_line_block_reader.sv
module tb_jenc_line_block_reader;
    logic        clk = 0;
    logic        rst_i = 1, start_i = 0, row_ready_i = 1;
    logic [7:0]  num_blocks_i = 0;
    logic        busy_o, done_o, rd_en_o, row_valid_o, last_o;
    logic [10:0] rd_addr_o;
    logic [63:0] rd_data_i = 0, row_data_o;
    logic [2:0]  row_idx_o;
    logic [7:0]  blk_idx_o;

    int total = 0, bad = 0;
    int cyc = 0;
    int rmode = 0;

    jenc_line_block_reader dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .num_blocks_i(num_blocks_i),
        .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
        .rd_data_i(rd_data_i), .row_valid_o(row_valid_o), .row_ready_i(row_ready_i),
        .row_data_o(row_data_o), .row_idx_o(row_idx_o), .blk_idx_o(blk_idx_o),
        .last_o(last_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ramword(input int a);
        logic [15:0] s;
        s = 16'(a);
        return {16'hDA7A, s, 16'h0F0F, ~s};
    endfunction

    // RAM model with one cycle of read latency
    always @(posedge clk) if (rd_en_o) rd_data_i <= ramword(int'(rd_addr_o));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Ready driver: mode 1 holds ready low for 10 cycles, then random
    initial begin
        int sc = 0;
        forever begin
            @(posedge clk); #1;
            if (rmode == 0) begin
                row_ready_i = 1; sc = 0;
            end else begin
                row_ready_i = (sc < 10) ? 1'b0 : 1'($urandom_range(0, 1));
                sc++;
            end
        end
    end

    // Model: a run of nb blocks is the word sequence k = 0..nb*8-1 with
    // data ram[k], row k%8, blk k/8, last on the final k.
    int          exp_nb = 0, issued = 0, accepted = 0, done_cnt = 0, max_addr = 0;
    int          t_start = 0, t_first_rd = -1, t_first_vld = -1, t_done = -1;
    logic [63:0] first_data = 0, row7_data = 0;
    logic        prev_stall = 0;
    logic [63:0] p_data;
    logic [2:0]  p_row;
    logic [7:0]  p_blk;
    logic        p_last;

    always @(negedge clk) begin
        if (rst_i) begin
            exp_nb <= 0; issued <= 0; accepted <= 0; prev_stall <= 0;
        end else begin
            automatic int  iss = issued, acc = accepted;
            automatic bit  hs  = row_valid_o && row_ready_i;
            if (prev_stall) begin
                chk("stall_valid", 64'(row_valid_o), 64'd1);
                chk("stall_data",  row_data_o, p_data);
                chk("stall_side",  64'({row_idx_o, blk_idx_o, last_o}), 64'({p_row, p_blk, p_last}));
            end
            if (start_i && !busy_o && num_blocks_i >= 1 && num_blocks_i <= 180) begin
                exp_nb <= int'(num_blocks_i); iss = 0; acc = 0; max_addr <= 0;
                t_start <= cyc; t_first_rd <= -1; t_first_vld <= -1; t_done <= -1;
            end
            if (rd_en_o) begin
                chk("rd_addr_lin", 64'(rd_addr_o), 64'(iss));
                chk("rd_addr_rng", 64'(rd_addr_o < 11'd1440), 64'd1);
                if (int'(rd_addr_o) > max_addr) max_addr <= int'(rd_addr_o);
                if (iss == 0) t_first_rd <= cyc;
                iss++;
            end
            if (row_valid_o && acc == 0 && t_first_vld < 0) t_first_vld <= cyc;
            if (hs) begin
                chk("row_data", row_data_o, ramword(acc));
                chk("row_idx",  64'(row_idx_o), 64'(acc % 8));
                chk("blk_idx",  64'(blk_idx_o), 64'(acc / 8));
                chk("last",     64'(last_o), 64'(acc == exp_nb * 8 - 1));
                if (acc == 0) first_data <= row_data_o;
                if (acc == 7) row7_data <= row_data_o;
                acc++;
            end
            if (hs || done_o) begin
                chk("done", 64'(done_o), 64'(hs && acc == exp_nb * 8));
                if (done_o) begin done_cnt <= done_cnt + 1; t_done <= cyc; end
            end
            if (rd_en_o) chk("credits", 64'(iss - acc <= 2), 64'd1);
            issued <= iss; accepted <= acc;
            prev_stall <= row_valid_o && !row_ready_i;
            p_data <= row_data_o; p_row <= row_idx_o; p_blk <= blk_idx_o; p_last <= last_o;
        end
    end

    task automatic chk_reset_vals(input string nm);
        @(negedge clk);
        chk({nm, "_ctl"}, 64'({busy_o, done_o, rd_en_o, row_valid_o, last_o}), 64'd0);
        chk({nm, "_addr"}, 64'(rd_addr_o), 64'd0);
        chk({nm, "_side"}, 64'({row_idx_o, blk_idx_o}), 64'd0);
    endtask

    task automatic run(input int nb, input int rm, input bit extra);
        int d0, n;
        d0 = done_cnt; n = 0;
        rmode = rm;
        @(posedge clk); #1; start_i = 1; num_blocks_i = 8'(nb);
        @(posedge clk); #1; start_i = 0;
        while (done_cnt == d0 && n < nb * 32 + 100) begin
            @(posedge clk); #1;
            start_i = extra && (n == 4);
            num_blocks_i = start_i ? 8'd1 : 8'(nb);
            n++;
        end
        start_i = 0; rmode = 0;
        @(negedge clk);
        chk("done_once", 64'(done_cnt - d0), 64'd1);
        chk("row_count", 64'(accepted), 64'(nb * 8));
        chk("busy_after", 64'(busy_o), 64'd0);
    endtask

    initial begin
        int d0, n;
        repeat (3) @(posedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1; rst_i = 0;

        // 1: single block, checks latency and literal data
        run(1, 0, 0);
        chk("t1_first_rd",  64'(t_first_rd - t_start), 64'd1);
        chk("t1_first_vld", 64'(t_first_vld - t_start), 64'd3);
        chk("t1_done",      64'(t_done - t_start), 64'd10);
        chk("t1_row0_data", first_data, 64'hDA7A_0000_0F0F_FFFF);
        chk("t1_row7_data", row7_data,  64'hDA7A_0007_0F0F_FFF8);

        // 2: full stripe
        run(180, 0, 0);
        chk("t2_max_addr", 64'(max_addr), 64'd1439);
        chk("t2_done",     64'(t_done - t_start), 64'd1442);

        // 3: backpressure
        run(4, 1, 0);

        // 4: illegal block counts are ignored
        for (int k = 0; k < 2; k++) begin
            d0 = done_cnt;
            @(posedge clk); #1; start_i = 1; num_blocks_i = (k == 0) ? 8'd0 : 8'd181;
            @(posedge clk); #1; start_i = 0;
            repeat (4) begin
                @(negedge clk);
                chk("t4_idle", 64'({busy_o, rd_en_o, done_o}), 64'd0);
            end
            chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
        end
        // start pulse while busy is ignored
        run(2, 0, 1);

        // 5: reset during block 2 with a read in flight
        d0 = done_cnt; n = 0;
        @(posedge clk); #1; start_i = 1; num_blocks_i = 8'd5;
        @(posedge clk); #1; start_i = 0;
        do begin @(negedge clk); n++; end
        while (!(rd_en_o && rd_addr_o == 11'd20) && n < 200);
        chk("t5_reach", 64'(rd_addr_o), 64'd20);
        @(posedge clk); #1; rst_i = 1;
        @(posedge clk); #1; rst_i = 0;
        chk_reset_vals("t5_reset");
        chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
        run(1, 0, 0);
        chk("t5_row0_data", first_data, 64'hDA7A_0000_0F0F_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
